// File: rtl/i2c_master_if.sv
// Command-side bundle of the I2C master: start/busy/done handshake plus data words.
// modport slave is the controller end, modport master is the command source end.
`default_nettype none

interface i2c_master_if;
   logic        start;
   logic [6:0]  slv_addr;
   logic        rw;
   logic [2:0]  byte_cnt;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        busy;
   logic        done;
   logic        ack_err;

   modport slave (
      input  start, slv_addr, rw, byte_cnt, wdata,
      output rdata, busy, done, ack_err
   );

   modport master (
      output start, slv_addr, rw, byte_cnt, wdata,
      input  rdata, busy, done, ack_err
   );
endinterface

`default_nettype wire

// File: rtl/i2c_master.sv
// ============================================================================
// i2c_master : single-master I2C controller (START, 7-bit addr, 0..4 data
//              bytes write or read, STOP). Optional LED[15:0] status port
//              enabled by defining I2C_MASTER_LED_EN.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module i2c_master #(
   parameter int unsigned SCL_DIV = 250
) (
   input  logic          clk,
   input  logic          reset,
   i2c_master_if.slave   cmd,
   output logic          SCL,
   inout  wire           SDA
`ifdef I2C_MASTER_LED_EN
   ,
   output logic [15:0]   LED
`endif
);

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, STOP
   } state_t;

   localparam logic [15:0] QMAX = 16'(SCL_DIV - 1);

   state_t      state, state_nx;
   logic [15:0] qcnt;
   logic [1:0]  phase, phase_nx;
   logic [2:0]  bit_cnt;
   logic [1:0]  byte_idx;
   logic [6:0]  addr_r;
   logic        rw_r;
   logic [2:0]  nbytes;
   logic [31:0] wdata_r;
   logic [7:0]  rx_shift;
   logic        sda_smp;
   logic        scl_r, sda_low;
   logic        scl_nx, sda_low_nx;
   logic        accept, tick, cell_end, last_byte;
   logic [7:0]  tx_byte;
   logic        tx_bit;

   assign accept    = cmd.start && (state == IDLE);
   assign tick      = (state != IDLE) && (qcnt == QMAX);
   assign cell_end  = tick && (phase == 2'd3);
   assign last_byte = ({1'b0, byte_idx} == (nbytes - 3'd1));
   assign tx_byte   = (state == ADDR) ? {addr_r, rw_r} : wdata_r[{byte_idx, 3'b000} +: 8];
   assign tx_bit    = tx_byte[3'd7 - bit_cnt];

   assign SCL = scl_r;
   assign SDA = sda_low ? 1'b0 : 1'bz;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (cmd.start) state_nx = START;
         START:    if (cell_end) state_nx = ADDR;
         ADDR:     if (cell_end && bit_cnt == 3'd7) state_nx = ADDR_ACK;
         ADDR_ACK: if (cell_end) begin
                      if (sda_smp || nbytes == 3'd0) state_nx = STOP;
                      else if (rw_r)                 state_nx = RDATA;
                      else                           state_nx = WDATA;
                   end
         WDATA:    if (cell_end && bit_cnt == 3'd7) state_nx = WACK;
         WACK:     if (cell_end) state_nx = (sda_smp || last_byte) ? STOP : WDATA;
         RDATA:    if (cell_end && bit_cnt == 3'd7) state_nx = RACK;
         RACK:     if (cell_end) state_nx = last_byte ? STOP : RDATA;
         STOP:     if (cell_end) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase

      // Pin levels for the quarter about to begin; SDA only moves at Q1 entry
      // inside bit cells so it is stable whenever SCL is high.
      phase_nx   = (state_nx != state) ? 2'd0 : phase + 2'd1;
      scl_nx     = phase_nx[1];
      sda_low_nx = sda_low;
      case (state_nx)
         IDLE: begin
            scl_nx     = 1'b1;
            sda_low_nx = 1'b0;
         end
         START: begin
            scl_nx     = (phase_nx != 2'd3);
            sda_low_nx = phase_nx[1];
         end
         ADDR, WDATA:            if (phase_nx == 2'd1) sda_low_nx = ~tx_bit;
         ADDR_ACK, WACK, RDATA:  if (phase_nx == 2'd1) sda_low_nx = 1'b0;
         RACK:                   if (phase_nx == 2'd1) sda_low_nx = ~last_byte;
         STOP:                   sda_low_nx = (phase_nx != 2'd3);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         qcnt        <= '0;
         phase       <= '0;
         bit_cnt     <= '0;
         byte_idx    <= '0;
         addr_r      <= '0;
         rw_r        <= 1'b0;
         nbytes      <= '0;
         wdata_r     <= '0;
         rx_shift    <= '0;
         sda_smp     <= 1'b1;
         scl_r       <= 1'b1;
         sda_low     <= 1'b0;
         cmd.rdata   <= '0;
         cmd.busy    <= 1'b0;
         cmd.done    <= 1'b0;
         cmd.ack_err <= 1'b0;
      end else begin
         cmd.done <= 1'b0;
         if (accept) begin
            addr_r      <= cmd.slv_addr;
            rw_r        <= cmd.rw;
            nbytes      <= (cmd.byte_cnt > 3'd4) ? 3'd4 : cmd.byte_cnt;
            wdata_r     <= cmd.wdata;
            cmd.rdata   <= '0;
            cmd.ack_err <= 1'b0;
            cmd.busy    <= 1'b1;
            qcnt        <= '0;
            phase       <= '0;
            bit_cnt     <= '0;
            byte_idx    <= '0;
         end else if (state != IDLE) begin
            qcnt <= tick ? 16'd0 : qcnt + 16'd1;
            if (tick) begin
               phase   <= phase_nx;
               scl_r   <= scl_nx;
               sda_low <= sda_low_nx;
            end
            if (state_nx != state) bit_cnt <= '0;
            else if (cell_end)     bit_cnt <= bit_cnt + 3'd1;

            // Last clk of Q2 is the sampling point for both ACK and read data.
            if (tick && phase == 2'd2) begin
               sda_smp <= SDA;
               if (state == RDATA) rx_shift <= {rx_shift[6:0], SDA};
            end

            if (cell_end) begin
               case (state)
                  ADDR_ACK: if (sda_smp) cmd.ack_err <= 1'b1;
                  WACK: begin
                     if (sda_smp) cmd.ack_err <= 1'b1;
                     else         byte_idx    <= byte_idx + 2'd1;
                  end
                  RACK: begin
                     cmd.rdata[{byte_idx, 3'b000} +: 8] <= rx_shift;
                     byte_idx <= byte_idx + 2'd1;
                  end
                  STOP: begin
                     cmd.done <= 1'b1;
                     cmd.busy <= 1'b0;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

`ifdef I2C_MASTER_LED_EN
   logic [7:0] led_byte;
   logic [7:0] led_code;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                         led_byte <= '0;
      else if (cell_end && state == WACK) led_byte <= tx_byte;
      else if (cell_end && state == RACK) led_byte <= rx_shift;
   end

   always_comb begin
      led_code = 8'h80;
      case (state)
         IDLE:     led_code = 8'h80;
         START:    led_code = 8'h40;
         ADDR:     led_code = 8'h20;
         ADDR_ACK: led_code = 8'h10;
         WDATA:    led_code = 8'h08;
         WACK:     led_code = 8'h04;
         RDATA:    led_code = 8'h02;
         RACK:     led_code = 8'h01;
         STOP:     led_code = 8'h0F;
         default:  led_code = 8'h80;
      endcase
   end

   assign LED = {led_code, led_byte};
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2c_master.sv
// Scoreboard bench for i2c_master with a behavioural 4-register I2C slave at 7'h55.
`default_nettype none

module tb_i2c_master;
   localparam int DIV = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   wire  scl;
   wire  sda;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   i2c_master_if cmd_if();

`ifdef I2C_MASTER_LED_EN
   logic [15:0] led;
`endif

   i2c_master #(.SCL_DIV(DIV)) dut (
      .clk   (clk),
      .reset (rst_n),
      .cmd   (cmd_if),
      .SCL   (scl),
      .SDA   (sda)
`ifdef I2C_MASTER_LED_EN
      ,
      .LED   (led)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pullup (sda);

   // ---------------- behavioural slave ----------------
   localparam int S_IDLE = 0, S_RXA = 1, S_AA = 2, S_RXD = 3, S_AD = 4, S_TX = 5, S_MACK = 6;
   logic       s_drive = 1'b0;
   int         s_st = S_IDLE;
   int         s_cnt = 0;
   logic [7:0] s_sh = 8'h00;
   logic [7:0] s_tx = 8'h00;
   logic [1:0] s_ptr = 2'd0;
   logic       s_rd = 1'b0;
   logic       s_mack = 1'b1;
   logic       scl_p = 1'b1;
   logic       sda_p = 1'b1;
   int         stops = 0;
   logic [7:0] regs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

   assign sda = s_drive ? 1'b0 : 1'bz;

   always @(posedge clk) begin
      scl_p <= scl;
      sda_p <= sda;
      if (scl && scl_p && sda_p && !sda) begin
         s_st <= S_RXA; s_cnt <= 0; s_ptr <= 2'd0; s_drive <= 1'b0;
      end else if (scl && scl_p && !sda_p && sda) begin
         s_st <= S_IDLE; s_drive <= 1'b0; stops <= stops + 1;
      end else if (scl && !scl_p) begin
         if (s_st == S_RXA || s_st == S_RXD) begin
            s_sh <= {s_sh[6:0], sda}; s_cnt <= s_cnt + 1;
         end else if (s_st == S_TX) begin
            s_cnt <= s_cnt + 1;
         end else if (s_st == S_MACK) begin
            s_mack <= sda;
         end
      end else if (!scl && scl_p) begin
         case (s_st)
            S_RXA: if (s_cnt == 8) begin
               if (s_sh[7:1] == 7'h55) begin
                  s_drive <= 1'b1; s_rd <= s_sh[0]; s_st <= S_AA;
               end else s_st <= S_IDLE;
            end
            S_AA: begin
               s_cnt <= 0;
               if (s_rd) begin
                  s_tx <= regs[s_ptr]; s_drive <= !regs[s_ptr][7]; s_st <= S_TX;
               end else begin
                  s_drive <= 1'b0; s_st <= S_RXD;
               end
            end
            S_RXD: if (s_cnt == 8) begin
               regs[s_ptr] <= s_sh; s_ptr <= s_ptr + 2'd1; s_drive <= 1'b1; s_st <= S_AD;
            end
            S_AD: begin s_drive <= 1'b0; s_st <= S_RXD; s_cnt <= 0; end
            S_TX: begin
               if (s_cnt == 8) begin
                  s_drive <= 1'b0; s_st <= S_MACK; s_ptr <= s_ptr + 2'd1;
               end else s_drive <= !s_tx[7 - s_cnt];
            end
            S_MACK: begin
               if (!s_mack) begin
                  s_tx <= regs[s_ptr]; s_drive <= !regs[s_ptr][7]; s_cnt <= 0; s_st <= S_TX;
               end else begin
                  s_drive <= 1'b0; s_st <= S_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] rdata;
      logic        ack;
      int          lat;
      int          acc;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (cmd_if.done === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: got done=1 expected no pending command");
            end else begin
               mon_e = exp_q.pop_front();
               chk("rdata", cmd_if.rdata, mon_e.rdata);
               chk("ack_err", {31'd0, cmd_if.ack_err}, {31'd0, mon_e.ack});
               chk("latency", cyc - mon_e.acc, mon_e.lat);
               chk("busy_at_done", {31'd0, cmd_if.busy}, 32'd0);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [6:0] a, input logic r, input logic [2:0] n,
                        input logic [31:0] wd, input bit push,
                        input logic [31:0] er, input logic ea, input int lat);
      exp_t e;
      @(negedge clk);
      cmd_if.slv_addr = a; cmd_if.rw = r; cmd_if.byte_cnt = n; cmd_if.wdata = wd;
      cmd_if.start = 1'b1;
      e.rdata = er; e.ack = ea; e.lat = lat; e.acc = cyc + 1;
      if (push) exp_q.push_back(e);
      @(negedge clk);
      cmd_if.start = 1'b0;
      chk("busy_after_accept", {31'd0, cmd_if.busy}, 32'd1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (cmd_if.done !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         checks++; errors++;
         $display("FAIL done_timeout: got no done expected done within 5000 cycles");
      end
      @(negedge clk);
   endtask

   task automatic chk_regs(input string nm, input logic [31:0] expv);
      chk(nm, {regs[3], regs[2], regs[1], regs[0]}, expv);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int st0;
      int acc;
      cmd_if.start = 1'b0; cmd_if.slv_addr = '0; cmd_if.rw = 1'b0;
      cmd_if.byte_cnt = '0; cmd_if.wdata = '0;

      repeat (3) @(negedge clk);
      chk("rst_scl", {31'd0, scl}, 32'd1);
      chk("rst_sda", {31'd0, sda}, 32'd1);
      chk("rst_busy", {31'd0, cmd_if.busy}, 32'd0);
      chk("rst_done", {31'd0, cmd_if.done}, 32'd0);
      chk("rst_ack_err", {31'd0, cmd_if.ack_err}, 32'd0);
      chk("rst_rdata", cmd_if.rdata, 32'd0);
`ifdef I2C_MASTER_LED_EN
      chk("rst_led", {16'd0, led}, 32'h0000_8000);
`endif
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // write two bytes: (8 + 36*3) * 4 = 464
      issue(7'h55, 1'b0, 3'd2, 32'h0000_BEEF, 1, 32'h0, 1'b0, 464);
      wait_done();
      chk_regs("regs_after_beef", 32'h0000_BEEF);

      // write four bytes: (8 + 36*5) * 4 = 752
      issue(7'h55, 1'b0, 3'd4, 32'h4433_2211, 1, 32'h0, 1'b0, 752);
      wait_done();
      chk_regs("regs_after_4411", 32'h4433_2211);

      // read four bytes with an ignored start pulse in the middle
      st0 = stops;
      issue(7'h55, 1'b1, 3'd4, 32'h0, 1, 32'h4433_2211, 1'b0, 752);
      repeat (100) @(negedge clk);
      cmd_if.slv_addr = 7'h23; cmd_if.rw = 1'b0; cmd_if.start = 1'b1;
      @(negedge clk);
      cmd_if.start = 1'b0;
      chk("busy_mid_pulse", {31'd0, cmd_if.busy}, 32'd1);
      wait_done();
      chk("read_stop_seen", stops - st0, 1);
      chk("no_reaccept", {31'd0, cmd_if.busy}, 32'd0);
      chk_regs("regs_after_read", 32'h4433_2211);

      // wrong address: 44 * 4 = 176, ack_err set, registers untouched
      st0 = stops;
      issue(7'h23, 1'b0, 3'd1, 32'h0000_00FF, 1, 32'h0, 1'b1, 176);
      wait_done();
      chk("nack_stop_seen", stops - st0, 1);
      chk_regs("regs_after_nack", 32'h4433_2211);

      // read two bytes: upper bytes zero, ack_err cleared by acceptance
      issue(7'h55, 1'b1, 3'd2, 32'h0, 1, 32'h0000_2211, 1'b0, 464);
      wait_done();

      // zero-byte write: (8 + 36) * 4 = 176
      issue(7'h55, 1'b0, 3'd0, 32'hFFFF_FFFF, 1, 32'h0, 1'b0, 176);
      wait_done();
      chk_regs("regs_after_zero_write", 32'h4433_2211);

      // byte_cnt=7 behaves as 4
      issue(7'h55, 1'b1, 3'd7, 32'h0, 1, 32'h4433_2211, 1'b0, 752);
      wait_done();

      // reset during WDATA bit 3 (40*4 + 3*16 + 4 cycles after acceptance)
      issue(7'h55, 1'b0, 3'd2, 32'h0000_1234, 0, 32'h0, 1'b0, 0);
      acc = cyc - 1;
      while (cyc < acc + 212) @(negedge clk);
`ifdef I2C_MASTER_LED_EN
      chk("led_wdata_state", {24'd0, led[15:8]}, 32'h08);
`endif
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_scl", {31'd0, scl}, 32'd1);
      chk("midrst_sda", {31'd0, sda}, 32'd1);
      chk("midrst_busy", {31'd0, cmd_if.busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk_regs("regs_after_abort", 32'h4433_2211);

      // recovery write of 8'hA5: (8 + 36*2) * 4 = 320
      issue(7'h55, 1'b0, 3'd1, 32'h0000_00A5, 1, 32'h0, 1'b0, 320);
      wait_done();
      chk_regs("regs_after_a5", 32'h4433_22A5);
`ifdef I2C_MASTER_LED_EN
      chk("led_last_byte", {16'd0, led}, 32'h0000_80A5);
`endif

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
